// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit with HI/LO for the MIPS150 execute stage.
// Latency: MULT(U)/DIV(U) write HI/LO 32 edges after accept (33 for signed ops with SIGNED_MULDIV_EN); MTHI/MTLO write at the accept edge.
// Backpressure: start is ignored while busy; the pipeline stalls on busy. Optional macro: SIGNED_MULDIV_EN.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
`ifdef SIGNED_MULDIV_EN
  localparam logic [2:0] S_FIX  = 3'd3;
`endif
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state;
  logic [CNT_W-1:0]   cnt;
  // acc is the product accumulator for multiply and {remainder, quotient} for divide
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opa;   // multiplicand
  logic [WIDTH-1:0]   opb;   // multiplier (shifts right) or divisor
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               last;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;

`ifdef SIGNED_MULDIV_EN
  logic               sgn_op;    // current mult/div is signed and needs the FIX cycle
  logic               is_div;
  logic               neg_q;     // operand signs differ: negate product / quotient
  logic               neg_r;     // dividend negative: remainder takes its sign
  logic               div_zero;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_quot;
  logic [WIDTH-1:0]   fix_rem;
`endif

  // Operand conditioning at accept: signed ops iterate on magnitudes
`ifdef SIGNED_MULDIV_EN
  always_comb begin
    in_a = A;
    in_b = B;
    if (op[1] && A[WIDTH-1]) in_a = -A;
    if (op[1] && B[WIDTH-1]) in_b = -B;
  end
`else
  always_comb begin
    in_a = A;
    in_b = B;
  end
`endif

  // One shift-add multiply step and one restoring divide step, shared by the FSM
  always_comb begin
    last      = &cnt;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (opb[0] ? opa : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = {1'b0, div_shift} - {2'b00, opb};
    div_ok    = ~div_diff[WIDTH+1];
    div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ok};
  end

`ifdef SIGNED_MULDIV_EN
  // Sign correction of the magnitude result during the FIX cycle
  always_comb begin
    fix_prod = neg_q ? -acc : acc;
    fix_quot = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    fix_rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (div_zero) fix_quot = {WIDTH{1'b1}};
  end
`endif

  // Control FSM, datapath registers and architectural HI/LO
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
`ifdef SIGNED_MULDIV_EN
      sgn_op   <= 1'b0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
`ifdef SIGNED_MULDIV_EN
            sgn_op   <= op[1] & ~op[2];
            is_div   <= op[0];
            neg_q    <= op[1] & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r    <= op[1] & A[WIDTH-1];
            div_zero <= (B == '0);
`endif
            case (op)
              3'b000, 3'b010: begin
                opa   <= in_a;
                opb   <= in_b;
                acc   <= '0;
                cnt   <= '0;
                state <= S_MUL;
              end
              3'b001, 3'b011: begin
                opb   <= in_b;
                acc   <= {{WIDTH{1'b0}}, in_a};
                cnt   <= '0;
                state <= S_DIV;
              end
              3'b100: begin
                hi_q  <= A;
                state <= S_IDLE;
              end
              3'b101: begin
                lo_q  <= A;
                state <= S_IDLE;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc <= mul_next;
          opb <= opb >> 1;
          cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (last) begin
`ifdef SIGNED_MULDIV_EN
            if (sgn_op) state <= S_FIX;
            else
`endif
            begin
              hi_q   <= mul_next[2*WIDTH-1:WIDTH];
              lo_q   <= mul_next[WIDTH-1:0];
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (last) begin
`ifdef SIGNED_MULDIV_EN
            if (sgn_op) state <= S_FIX;
            else
`endif
            begin
              hi_q   <= div_next[2*WIDTH-1:WIDTH];
              lo_q   <= div_next[WIDTH-1:0];
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
`ifdef SIGNED_MULDIV_EN
        S_FIX: begin
          if (is_div) begin
            hi_q <= fix_rem;
            lo_q <= fix_quot;
          end else begin
            hi_q <= fix_prod[2*WIDTH-1:WIDTH];
            lo_q <= fix_prod[WIDTH-1:0];
          end
          done_q <= 1'b1;
          state  <= S_DONE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status and architectural outputs
  always_comb begin
    busy = (state == S_MUL) || (state == S_DIV);
`ifdef SIGNED_MULDIV_EN
    if (state == S_FIX) busy = 1'b1;
`endif
    done = done_q;
    HI   = hi_q;
    LO   = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases with literal results, then randomized traffic
// checked every cycle against a transaction-level model (arithmetic result + fixed latency).
module tb_mult_div_unit;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_DIVU  = 3'b001;
  localparam logic [2:0] OP_MULT  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef SIGNED_MULDIV_EN
  localparam int LAT_S = 33;
`else
  localparam int LAT_S = 32;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_pass   = 0;

  mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference arithmetic: returns {HI, LO}
  function automatic logic [63:0] ref_calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit          sgn;
    longint      sa, sb, q, r;
    logic [63:0] qv, rv, p;
`ifdef SIGNED_MULDIV_EN
    sgn = o[1];
`else
    sgn = 1'b0;
`endif
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (!o[0]) begin
      if (sgn) p = sa * sb;
      else     p = {32'b0, a} * {32'b0, b};
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  function automatic int ref_lat(input logic [2:0] o);
`ifdef SIGNED_MULDIV_EN
    return o[1] ? 33 : 32;
`else
    return (o == 3'b111) ? 32 : 32;
`endif
  endfunction

  // Transaction model: an op occupies the unit for its latency, then results appear with a done pulse
  int          m_cnt;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_done;
  always @(posedge Clock or posedge Reset) begin
    bit idle;
    if (Reset) begin
      m_cnt = 0; m_hi = 0; m_lo = 0; m_done = 0; p_hi = 0; p_lo = 0;
    end else begin
      idle   = (m_cnt == 0);
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end
      if (idle && start) begin
        if (op == OP_MTHI) m_hi = A;
        else if (op == OP_MTLO) m_lo = A;
        else if (!op[2]) begin
          {p_hi, p_lo} = ref_calc(op, A, B);
          m_cnt = ref_lat(op);
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge Clock) begin
    chk("busy", {31'b0, busy}, {31'b0, (m_cnt > 0)});
    chk("done", {31'b0, done}, {31'b0, m_done});
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge Clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int k);
    k = 0;
    while (!done && k < 40) begin
      @(negedge Clock);
      k++;
    end
    if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int k;
    start = 0; op = 0; A = 0; B = 0;
    #1 Reset = 1'b1;
    repeat (2) @(negedge Clock);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    Reset = 1'b0;
    @(negedge Clock);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_busy_T", {31'b0, busy}, 32'd1);
    wait_done("multu", k);
    chk("multu_lat", k, 32);
    chk("multu_hi", HI, 32'hFFFF_FFFE);
    chk("multu_lo", LO, 32'h0000_0001);
    @(negedge Clock);
    chk("done_pulse", {31'b0, done}, 32'd0);

    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done("divu", k);
    chk("divu_lo", LO, 32'h0000_000E);
    chk("divu_hi", HI, 32'h0000_0002);
    issue(OP_DIVU, 32'd5, 32'd0);
    wait_done("divz", k);
    chk("divz_lat", k, 32);
    chk("divz_lo", LO, 32'hFFFF_FFFF);
    chk("divz_hi", HI, 32'h0000_0005);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult", k);
    chk("mult_lat", k, LAT_S);
`ifdef SIGNED_MULDIV_EN
    chk("mult_hi", HI, 32'hFFFF_FFFF);
`else
    chk("mult_hi", HI, 32'h0000_0004);
`endif
    chk("mult_lo", LO, 32'hFFFF_FFF1);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", k);
`ifdef SIGNED_MULDIV_EN
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
`else
    chk("div_lo", LO, 32'h7FFF_FFFC);
    chk("div_hi", HI, 32'h0000_0001);
`endif

    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_hi", HI, 32'h1234_5678);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    chk("mthi_done", {31'b0, done}, 32'd0);
    issue(OP_MTLO, 32'h0000_ABCD, 32'd0);
    chk("mtlo_lo", LO, 32'h0000_ABCD);

    issue(OP_MULTU, 32'd3, 32'd7);
    repeat (4) @(negedge Clock);
    issue(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
    chk("mtlo_ignored", LO, 32'h0000_ABCD);
    wait_done("mul_ign", k);
    chk("mul_ign_lo", LO, 32'd21);
    chk("mul_ign_hi", HI, 32'd0);

    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    issue(OP_DIVU, 32'd1000, 32'd3);
    wait_done("div_after_rst", k);
    chk("div_after_rst_lat", k, 32);
    chk("div_after_rst_lo", LO, 32'd333);
    chk("div_after_rst_hi", HI, 32'd1);

    issue(OP_MULTU, 32'd6, 32'd7);
    wait_done("b2b_first", k);
    chk("b2b_first_lo", LO, 32'd42);
    issue(OP_MULTU, 32'd9, 32'd11);
    chk("b2b_done_low", {31'b0, done}, 32'd0);
    chk("b2b_busy_high", {31'b0, busy}, 32'd1);
    wait_done("b2b_second", k);
    chk("b2b_lat", k, 32);
    chk("b2b_lo", LO, 32'd99);

    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 3'($urandom_range(0, 7));
      A     = $urandom;
      case ($urandom_range(0, 9))
        0: B = 32'd0;
        1: B = 32'($urandom_range(1, 15));
        2: B = 32'hFFFF_FFFF;
        default: B = $urandom;
      endcase
      @(negedge Clock);
    end
    start = 1'b0;
    repeat (40) @(negedge Clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
